result_checker: RTL and testbench

- Parametrised successor to the verification-platform scoreboard.
- Compares chip results arriving from the AES receive path against expected results popped from the data generator's result FIFO.
- Keeps saturating total, correct, mismatch and timeout counters, and detects results that are missing or unexpected.
- Can halt the platform after a configurable error count.
- Sits between the rx deserialiser, the generator result FIFO and the host status registers, all in the core clock domain.

---
 rtl/result_checker_pkg.sv | 26 ++
 rtl/result_checker_sat.sv | 42 ++++
 rtl/result_checker.sv | 194 +++++++++++++++++++
 tb/tb_result_checker.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_checker_pkg.sv
// Shared definitions for the result checker.
//   - state_e  : checker state (IDLE / RUN / HALT), 2-bit encoding
//   - sat_inc  : saturating increment for counters up to SAT_MAX_W bits wide
//   - DATA_W_DEF / CNT_W_DEF : default widths of result words and counters
package result_checker_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int CNT_W_DEF  = 32;
    localparam int SAT_MAX_W  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    // Increment v, but stop at the all-ones value of a w-bit counter.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                     input int unsigned          w);
        logic [SAT_MAX_W-1:0] top;
        top = (w >= SAT_MAX_W) ? {SAT_MAX_W{1'b1}}
                               : ((SAT_MAX_W'(1) << w) - SAT_MAX_W'(1));
        sat_inc = (v >= top) ? top : v + SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/result_checker_sat.sv
// sat_counter: W-bit saturating event counter.
// Ports:
//   clk  - core clock
//   rst  - synchronous active-high reset (counter to 0)
//   inc  - count one event this cycle
//   clr  - synchronous clear (wins over inc)
//   q    - current count, sticks at 2^W-1
module sat_counter
    import result_checker_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = W'(sat_inc(SAT_MAX_W'(q_q), W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/result_checker.sv
// result_checker: compares chip results from the rx deserialiser against
// expected results taken from the head of the generator's show-ahead FIFO.
// Keeps saturating statistics, times out expected results that never get a
// chip result, counts unexpected chip results and can halt after MAX_ERR
// errors.
// Ports:
//   clk, rst        - core clock, synchronous active-high reset
//   enable          - checking enabled (IDLE <-> RUN)
//   clr             - synchronous clear of counters, flags and state
//   chip_data/en    - chip result and its one-cycle strobe
//   exp_data/empty  - head of expected FIFO and its empty flag
//   exp_require     - combinational pop strobe to the expected FIFO
//   total, correct, mismatch, timeouts, unexpected - saturating counters
//   halted          - error limit reached
//   busy            - running with an expected result pending
// Optional build macro RESULT_CHECKER_CAPTURE_EN adds a sticky capture of
// the first mismatch: cap_valid, cap_chip, cap_exp, cap_index.
module result_checker
    import result_checker_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = 1024,
    parameter int MAX_ERR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clr,
    input  logic [DATA_W-1:0] chip_data,
    input  logic              chip_en,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              exp_empty,
    output logic              exp_require,
    output logic [CNT_W-1:0]  total,
    output logic [CNT_W-1:0]  correct,
    output logic [CNT_W-1:0]  mismatch,
    output logic [CNT_W-1:0]  timeouts,
    output logic [CNT_W-1:0]  unexpected,
    output logic              halted,
    output logic              busy
`ifdef RESULT_CHECKER_CAPTURE_EN
    ,
    output logic              cap_valid,
    output logic [DATA_W-1:0] cap_chip,
    output logic [DATA_W-1:0] cap_exp,
    output logic [CNT_W-1:0]  cap_index
`endif
);

    // The wait counter only ever reaches TIMEOUT-1 before being cleared.
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] err_next;

    logic live;
    logic match;
    logic cmp_ev;
    logic unexp_ev;
    logic expire_ev;
    logic err_inc;
    logic halt_hit;

    // Events only exist in RUN and are dropped in a clr or rst cycle.
    assign live      = (state_q == RUN) && !clr && !rst;
    assign match     = (chip_data == exp_data);
    assign cmp_ev    = live && chip_en && !exp_empty;
    assign unexp_ev  = live && chip_en && exp_empty;
    // chip_en wins over expiry: a compare in the same cycle consumes the entry.
    assign expire_ev = live && (TIMEOUT != 0) && !chip_en && !exp_empty && (tmo_q == TMO_LAST);
    assign err_inc   = (cmp_ev && !match) || expire_ev || unexp_ev;

    // Halt on the same edge that brings the error count to the limit.
    assign err_next = CNT_W'(sat_inc(SAT_MAX_W'(err_cnt), CNT_W));
    assign halt_hit = (MAX_ERR != 0) && err_inc
                      && (SAT_MAX_W'(err_next) >= SAT_MAX_W'(MAX_ERR));

    assign exp_require = cmp_ev || expire_ev;
    assign busy        = (state_q == RUN) && !exp_empty;
    assign halted      = (state_q == HALT);

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (enable) state_d = RUN;
                RUN: begin
                    if (halt_hit) begin
                        state_d = HALT;
                    end else if (!enable) begin
                        state_d = IDLE;
                    end
                end
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    // Wait counter runs only in RUN; leaving RUN holds its value.
    always_comb begin
        tmo_d = tmo_q;
        if (clr) begin
            tmo_d = '0;
        end else if (state_q == RUN) begin
            if (chip_en || exp_empty || expire_ev) begin
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_total (
        .clk(clk), .rst(rst), .inc(cmp_ev || expire_ev), .clr(clr), .q(total)
    );
    sat_counter #(.W(CNT_W)) u_correct (
        .clk(clk), .rst(rst), .inc(cmp_ev && match), .clr(clr), .q(correct)
    );
    sat_counter #(.W(CNT_W)) u_mismatch (
        .clk(clk), .rst(rst), .inc(cmp_ev && !match), .clr(clr), .q(mismatch)
    );
    sat_counter #(.W(CNT_W)) u_timeouts (
        .clk(clk), .rst(rst), .inc(expire_ev), .clr(clr), .q(timeouts)
    );
    sat_counter #(.W(CNT_W)) u_unexpected (
        .clk(clk), .rst(rst), .inc(unexp_ev), .clr(clr), .q(unexpected)
    );
    sat_counter #(.W(CNT_W)) u_errors (
        .clk(clk), .rst(rst), .inc(err_inc), .clr(clr), .q(err_cnt)
    );

`ifdef RESULT_CHECKER_CAPTURE_EN
    logic              cap_valid_q, cap_valid_d;
    logic [DATA_W-1:0] cap_chip_q, cap_chip_d;
    logic [DATA_W-1:0] cap_exp_q, cap_exp_d;
    logic [CNT_W-1:0]  cap_index_q, cap_index_d;

    // Only the first mismatch is kept; total is sampled before it counts it.
    always_comb begin
        cap_valid_d = cap_valid_q;
        cap_chip_d  = cap_chip_q;
        cap_exp_d   = cap_exp_q;
        cap_index_d = cap_index_q;
        if (clr) begin
            cap_valid_d = 1'b0;
            cap_chip_d  = '0;
            cap_exp_d   = '0;
            cap_index_d = '0;
        end else if (cmp_ev && !match && !cap_valid_q) begin
            cap_valid_d = 1'b1;
            cap_chip_d  = chip_data;
            cap_exp_d   = exp_data;
            cap_index_d = total;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_valid_q <= 1'b0;
            cap_chip_q  <= '0;
            cap_exp_q   <= '0;
            cap_index_q <= '0;
        end else begin
            cap_valid_q <= cap_valid_d;
            cap_chip_q  <= cap_chip_d;
            cap_exp_q   <= cap_exp_d;
            cap_index_q <= cap_index_d;
        end
    end

    assign cap_valid = cap_valid_q;
    assign cap_chip  = cap_chip_q;
    assign cap_exp   = cap_exp_q;
    assign cap_index = cap_index_q;
`endif

endmodule

// File: tb/tb_result_checker.sv
// Bench for result_checker. Two instances share the control and chip inputs
// but each has its own expected FIFO held in the bench:
//   dut_a: CNT_W=4, TIMEOUT=8,    MAX_ERR=0 (saturation, timeouts)
//   dut_b: CNT_W=8, TIMEOUT=1024, MAX_ERR=2 (halt, capture)
module tb_result_checker;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst, enable, clr, chip_en;
    logic [DW-1:0] chip_data;
    logic [DW-1:0] exp_data0, exp_data1;
    logic          exp_empty0, exp_empty1;
    logic          req0, req1;
    logic [3:0]    total0, correct0, mismatch0, timeouts0, unexpected0;
    logic [7:0]    total1, correct1, mismatch1, timeouts1, unexpected1;
    logic          halted0, halted1, busy0, busy1;
`ifdef RESULT_CHECKER_CAPTURE_EN
    logic          cap_valid0, cap_valid1;
    logic [DW-1:0] cap_chip0, cap_exp0, cap_chip1, cap_exp1;
    logic [3:0]    cap_index0;
    logic [7:0]    cap_index1;
`endif

    always #5 clk = ~clk;

    result_checker #(.DATA_W(DW), .CNT_W(4), .TIMEOUT(8), .MAX_ERR(0)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .clr(clr),
        .chip_data(chip_data), .chip_en(chip_en),
        .exp_data(exp_data0), .exp_empty(exp_empty0), .exp_require(req0),
        .total(total0), .correct(correct0), .mismatch(mismatch0),
        .timeouts(timeouts0), .unexpected(unexpected0),
        .halted(halted0), .busy(busy0)
`ifdef RESULT_CHECKER_CAPTURE_EN
        , .cap_valid(cap_valid0), .cap_chip(cap_chip0), .cap_exp(cap_exp0), .cap_index(cap_index0)
`endif
    );

    result_checker #(.DATA_W(DW), .CNT_W(8), .TIMEOUT(1024), .MAX_ERR(2)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .clr(clr),
        .chip_data(chip_data), .chip_en(chip_en),
        .exp_data(exp_data1), .exp_empty(exp_empty1), .exp_require(req1),
        .total(total1), .correct(correct1), .mismatch(mismatch1),
        .timeouts(timeouts1), .unexpected(unexpected1),
        .halted(halted1), .busy(busy1)
`ifdef RESULT_CHECKER_CAPTURE_EN
        , .cap_valid(cap_valid1), .cap_chip(cap_chip1), .cap_exp(cap_exp1), .cap_index(cap_index1)
`endif
    );

    // Behavioural reference: one record per instance.
    typedef struct {
        bit            active;
        bit            stopped;
        int            tmo;
        int            total, correct, mism, tmos, unexp, err;
        bit            cap_v;
        int            cap_idx;
        logic [DW-1:0] cap_c, cap_e;
    } model_t;

    typedef struct {
        bit            en;
        bit            ce;
        logic [DW-1:0] cd;
        bit            req;
        int            total, correct, mism, unexp;
    } vec_t;

    model_t        m0, m1;
    logic [DW-1:0] fifo0[$];
    logic [DW-1:0] fifo1[$];
    int            checks   = 0;
    int            failures = 0;
    bit            last_req0, last_req1;

    function automatic int satp(input int x, input int cmax);
        return (x >= cmax) ? cmax : x + 1;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock of the reference: decides this cycle's pop and next counters.
    function automatic void step(inout model_t m, input int cmax, input int maxerr,
                                 input int tlim, input bit en, input bit c, input bit r,
                                 input bit ce, input logic [DW-1:0] cd, input bit empty,
                                 input logic [DW-1:0] ed, output bit req);
        bit erred;
        req   = 1'b0;
        erred = 1'b0;
        if (r || c) begin
            m = '{default: 0};
            return;
        end
        if (m.stopped) return;
        if (!m.active) begin
            m.active = en;
            return;
        end
        if (ce) begin
            m.tmo = 0;
            if (!empty) begin
                req = 1'b1;
                if (cd == ed) begin
                    m.correct = satp(m.correct, cmax);
                end else begin
                    if (!m.cap_v) begin
                        m.cap_v   = 1'b1;
                        m.cap_idx = m.total;
                        m.cap_c   = cd;
                        m.cap_e   = ed;
                    end
                    m.mism = satp(m.mism, cmax);
                    erred  = 1'b1;
                end
                m.total = satp(m.total, cmax);
            end else begin
                m.unexp = satp(m.unexp, cmax);
                erred   = 1'b1;
            end
        end else if (empty) begin
            m.tmo = 0;
        end else if (tlim != 0 && m.tmo == tlim - 1) begin
            req    = 1'b1;
            m.tmo  = 0;
            m.tmos = satp(m.tmos, cmax);
            m.total = satp(m.total, cmax);
            erred  = 1'b1;
        end else begin
            m.tmo++;
        end
        if (erred) m.err = satp(m.err, cmax);
        if (erred && maxerr != 0 && m.err >= maxerr) m.stopped = 1'b1;
        else if (!en) m.active = 1'b0;
    endfunction

    task automatic check_state();
        chk("total_a", 64'(total0), 64'(m0.total));
        chk("correct_a", 64'(correct0), 64'(m0.correct));
        chk("mismatch_a", 64'(mismatch0), 64'(m0.mism));
        chk("timeouts_a", 64'(timeouts0), 64'(m0.tmos));
        chk("unexpected_a", 64'(unexpected0), 64'(m0.unexp));
        chk("halted_a", 64'(halted0), 64'(m0.stopped));
        chk("total_b", 64'(total1), 64'(m1.total));
        chk("correct_b", 64'(correct1), 64'(m1.correct));
        chk("mismatch_b", 64'(mismatch1), 64'(m1.mism));
        chk("timeouts_b", 64'(timeouts1), 64'(m1.tmos));
        chk("unexpected_b", 64'(unexpected1), 64'(m1.unexp));
        chk("halted_b", 64'(halted1), 64'(m1.stopped));
`ifdef RESULT_CHECKER_CAPTURE_EN
        chk("cap_valid_a", 64'(cap_valid0), 64'(m0.cap_v));
        chk("cap_valid_b", 64'(cap_valid1), 64'(m1.cap_v));
        if (m1.cap_v) begin
            chk("cap_index_b", 64'(cap_index1), 64'(m1.cap_idx));
            chk("cap_chip_b", 64'(cap_chip1), 64'(m1.cap_c));
            chk("cap_exp_b", 64'(cap_exp1), 64'(m1.cap_e));
        end
        if (m0.cap_v) begin
            chk("cap_index_a", 64'(cap_index0), 64'(m0.cap_idx));
            chk("cap_chip_a", 64'(cap_chip0), 64'(m0.cap_c));
        end
`endif
    endtask

    // Drive one cycle, check the combinational outputs, clock it, check state.
    task automatic cycle(input bit en, input bit c, input bit r, input bit ce,
                         input logic [DW-1:0] cd);
        bit e0, e1, r0, r1;
        enable    = en;
        clr       = c;
        rst       = r;
        chip_en   = ce;
        chip_data = cd;
        e0 = (fifo0.size() == 0);
        e1 = (fifo1.size() == 0);
        exp_empty0 = e0;
        exp_empty1 = e1;
        exp_data0  = e0 ? '0 : fifo0[0];
        exp_data1  = e1 ? '0 : fifo1[0];
        #1;
        chk("busy_a", 64'(busy0), 64'(m0.active && !m0.stopped && !e0));
        chk("busy_b", 64'(busy1), 64'(m1.active && !m1.stopped && !e1));
        step(m0, 15, 0, 8, en, c, r, ce, cd, e0, exp_data0, r0);
        step(m1, 255, 2, 1024, en, c, r, ce, cd, e1, exp_data1, r1);
        chk("exp_require_a", 64'(req0), 64'(r0));
        chk("exp_require_b", 64'(req1), 64'(r1));
        last_req0 = req0;
        last_req1 = req1;
        @(posedge clk);
        if (r0) void'(fifo0.pop_front());
        if (r1) void'(fifo1.pop_front());
        #1;
        check_state();
    endtask

    task automatic do_clr();
        fifo0.delete();
        fifo1.delete();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[8];
        int   nreq;
        logic [DW-1:0] w;

        // Table on dut_a: three expected words 1,2,3.
        vt[0] = '{en:1, ce:0, cd:16'h0, req:0, total:0, correct:0, mism:0, unexp:0};
        vt[1] = '{en:1, ce:1, cd:16'h1, req:1, total:1, correct:1, mism:0, unexp:0};
        vt[2] = '{en:1, ce:0, cd:16'h0, req:0, total:1, correct:1, mism:0, unexp:0};
        vt[3] = '{en:1, ce:1, cd:16'h5, req:1, total:2, correct:1, mism:1, unexp:0};
        vt[4] = '{en:1, ce:1, cd:16'h3, req:1, total:3, correct:2, mism:1, unexp:0};
        vt[5] = '{en:1, ce:1, cd:16'h7, req:0, total:3, correct:2, mism:1, unexp:1};
        vt[6] = '{en:0, ce:1, cd:16'h0, req:0, total:3, correct:2, mism:1, unexp:2};
        vt[7] = '{en:0, ce:1, cd:16'h0, req:0, total:3, correct:2, mism:1, unexp:2};

        m0 = '{default: 0};
        m1 = '{default: 0};
        rst = 1'b1; enable = 1'b0; clr = 1'b0; chip_en = 1'b0; chip_data = '0;
        exp_data0 = '0; exp_data1 = '0; exp_empty0 = 1'b1; exp_empty1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
        chk("reset_total_a", 64'(total0), 64'd0);
        chk("reset_halted_b", 64'(halted1), 64'd0);

        do_clr();
        fifo0.push_back(16'h1); fifo0.push_back(16'h2); fifo0.push_back(16'h3);
        for (int i = 0; i < 8; i++) begin
            cycle(vt[i].en, 1'b0, 1'b0, vt[i].ce, vt[i].cd);
            chk("tbl_req", 64'(last_req0), 64'(vt[i].req));
            chk("tbl_total", 64'(total0), 64'(vt[i].total));
            chk("tbl_correct", 64'(correct0), 64'(vt[i].correct));
            chk("tbl_mismatch", 64'(mismatch0), 64'(vt[i].mism));
            chk("tbl_unexpected", 64'(unexpected0), 64'(vt[i].unexp));
        end

        // Four matching results; pops coincide with chip_en.
        do_clr();
        for (int i = 1; i <= 4; i++) fifo0.push_back(16'(i));
        nreq = 0;
        w = 16'h1;
        for (int k = 1; k <= 17; k++) begin
            bit ce;
            ce = (k >= 10 && k <= 16 && (k % 2) == 0);
            cycle(k >= 5, 1'b0, 1'b0, ce, ce ? w : 16'h0);
            if (ce) w = w + 16'h1;
            chk("match_req_with_chip_en", 64'(last_req0), 64'(ce));
            nreq += int'(last_req0);
        end
        chk("match_total", 64'(total0), 64'd4);
        chk("match_correct", 64'(correct0), 64'd4);
        chk("match_mismatch", 64'(mismatch0), 64'd0);
        chk("match_pops", 64'(nreq), 64'd4);

        // Timeout on the 8th RUN cycle.
        do_clr();
        fifo0.push_back(16'h55);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
            chk("tmo_req", 64'(last_req0), 64'(k == 8));
        end
        chk("tmo_timeouts", 64'(timeouts0), 64'd1);
        chk("tmo_total", 64'(total0), 64'd1);

        // chip_en on the expiry cycle wins.
        do_clr();
        fifo0.push_back(16'h55);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int k = 1; k <= 8; k++) cycle(1'b1, 1'b0, 1'b0, k == 8, 16'h55);
        chk("tmo_tie_req", 64'(last_req0), 64'd1);
        chk("tmo_tie_timeouts", 64'(timeouts0), 64'd0);
        chk("tmo_tie_correct", 64'(correct0), 64'd1);
        chk("tmo_tie_total", 64'(total0), 64'd1);

        // Unexpected results with an empty FIFO.
        do_clr();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h9);
        chk("unexp_req1", 64'(last_req0), 64'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h9);
        chk("unexp_req2", 64'(last_req0), 64'd0);
        chk("unexp_count", 64'(unexpected0), 64'd2);
        chk("unexp_total", 64'(total0), 64'd0);

        // Mismatch capture, then halt on dut_b after two errors.
        do_clr();
        fifo1.push_back(16'hAAAA); fifo1.push_back(16'h0002); fifo1.push_back(16'h0003);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'hAAAB);
        chk("mm_mismatch", 64'(mismatch1), 64'd1);
        chk("mm_correct", 64'(correct1), 64'd0);
        chk("mm_total", 64'(total1), 64'd1);
        chk("mm_not_halted", 64'(halted1), 64'd0);
`ifdef RESULT_CHECKER_CAPTURE_EN
        chk("cap_valid", 64'(cap_valid1), 64'd1);
        chk("cap_exp", 64'(cap_exp1), 64'hAAAA);
        chk("cap_chip", 64'(cap_chip1), 64'hAAAB);
        chk("cap_index", 64'(cap_index1), 64'd0);
`endif
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h1234);
        chk("halt_set", 64'(halted1), 64'd1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0003);
        chk("halt_no_pop", 64'(last_req1), 64'd0);
        chk("halt_total_held", 64'(total1), 64'd2);
        chk("halt_correct_held", 64'(correct1), 64'd0);
        do_clr();
        chk("halt_clr_halted", 64'(halted1), 64'd0);
        chk("halt_clr_mismatch", 64'(mismatch1), 64'd0);
        chk("halt_clr_busy", 64'(busy1), 64'd0);

        // Saturation at 4 bits, then clr with a simultaneous chip_en.
        do_clr();
        for (int i = 0; i < 17; i++) fifo0.push_back(16'(i + 16'h100));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'(i + 16'h100));
        chk("sat_correct", 64'(correct0), 64'd15);
        chk("sat_total", 64'(total0), 64'd15);
        fifo0.push_back(16'h77);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h77);
        chk("clr_no_pop", 64'(last_req0), 64'd0);
        chk("clr_total", 64'(total0), 64'd0);
        chk("clr_correct", 64'(correct0), 64'd0);

        // Reset in the middle of a run.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h77);
        chk("pre_rst_total", 64'(total0), 64'd1);
        fifo0.push_back(16'h78);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'h78);
        chk("rst_no_pop", 64'(last_req0), 64'd0);
        chk("rst_total", 64'(total0), 64'd0);

        // Randomised traffic against the reference.
        do_clr();
        for (int n = 0; n < 3000; n++) begin
            bit ce, en, c, r;
            logic [DW-1:0] cd;
            if ($urandom_range(0, 3) == 0 && fifo0.size() < 8) begin
                w = 16'($urandom);
                fifo0.push_back(w);
                fifo1.push_back(w);
            end
            ce = ($urandom_range(0, 9) < 3);
            en = ($urandom_range(0, 15) != 0);
            c  = ($urandom_range(0, 127) == 0);
            r  = ($urandom_range(0, 511) == 0);
            if ($urandom_range(0, 3) == 0 || fifo0.size() == 0) cd = 16'($urandom);
            else cd = fifo0[0];
            cycle(en, c, r, ce, cd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
